demux_striping: RTL and testbench



---
 rtl/demux_striping.sv | 126 ++++++++++++
 tb/tb_demux_striping.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_striping.sv
// -----------------------------------------------------------------------------
// demux_striping
//
// Transmit-side two-lane striper. A single word stream arriving at the fast
// clock rate is split into aligned pairs. The first word of each pair goes to
// lane 0 and the second to lane 1. Each pair is held for two fast-clock
// cycles, so both lanes run at half rate and are always valid together. A
// word left without a partner at the end of a burst (an odd word) is flushed
// alone on lane 0. Lane assignment restarts at lane 0 after every gap, so the
// matching unstriping mux can rebuild the original order.
//
// Ports
//   clk_2f     in   fast clock; all state changes on its rising edge
//   reset_L    in   asynchronous, active-low reset
//   data_in    in   input word, sampled when valid_in=1
//   valid_in   in   one word per clk_2f cycle when high
//   data_out0  out  lane 0 word (1st, 3rd, 5th ... word of a burst)
//   valid_out0 out  lane 0 qualifier
//   data_out1  out  lane 1 word (2nd, 4th, 6th ... word of a burst)
//   valid_out1 out  lane 1 qualifier
//   pending    out  high while a lane 0 word is buffered awaiting its partner
// -----------------------------------------------------------------------------
module demux_striping #(
  parameter int WIDTH = 32
) (
  input  logic             clk_2f,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] data_out0,
  output logic             valid_out0,
  output logic [WIDTH-1:0] data_out1,
  output logic             valid_out1,
  output logic             pending
);

  // EMPTY: no word buffered. HALF: lane 0 word sits in buf0.
  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_e;

  localparam logic [1:0] HOLD_CYCLES = 2'd2;

  state_e           state_q,      state_d;
  logic [WIDTH-1:0] buf0_q,       buf0_d;
  logic [1:0]       hold_cnt_q,   hold_cnt_d;
  logic [WIDTH-1:0] data_out0_q,  data_out0_d;
  logic [WIDTH-1:0] data_out1_q,  data_out1_d;
  logic             valid_out0_q, valid_out0_d;
  logic             valid_out1_q, valid_out1_d;

  // Hold counter decrement that sticks at zero instead of wrapping.
  function automatic logic [1:0] hold_dec(input logic [1:0] cnt);
    return (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
  endfunction

  always_comb begin
    state_d      = state_q;
    buf0_d       = buf0_q;
    data_out0_d  = data_out0_q;
    data_out1_d  = data_out1_q;
    valid_out0_d = valid_out0_q;
    valid_out1_d = valid_out1_q;

    // Default path: no output load this cycle, so the held pair ages by one.
    // The valids fall on the edge where the count runs out; data is kept.
    hold_cnt_d = hold_dec(hold_cnt_q);
    if (hold_cnt_d == 2'd0) begin
      valid_out0_d = 1'b0;
      valid_out1_d = 1'b0;
    end

    unique case (state_q)
      EMPTY: begin
        if (valid_in) begin
          buf0_d  = data_in;
          state_d = HALF;
        end
      end
      HALF: begin
        // Either the partner arrives (pair load) or a gap flushes the lone
        // lane 0 word. Both reload the hold timer, which is what lets a
        // continuous stream reload exactly as the previous pair expires.
        data_out0_d  = buf0_q;
        valid_out0_d = 1'b1;
        hold_cnt_d   = HOLD_CYCLES;
        state_d      = EMPTY;
        if (valid_in) begin
          data_out1_d  = data_in;
          valid_out1_d = 1'b1;
        end else begin
          valid_out1_d = 1'b0;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= EMPTY;
      buf0_q       <= '0;
      hold_cnt_q   <= 2'd0;
      data_out0_q  <= '0;
      data_out1_q  <= '0;
      valid_out0_q <= 1'b0;
      valid_out1_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf0_q       <= buf0_d;
      hold_cnt_q   <= hold_cnt_d;
      data_out0_q  <= data_out0_d;
      data_out1_q  <= data_out1_d;
      valid_out0_q <= valid_out0_d;
      valid_out1_q <= valid_out1_d;
    end
  end

  assign data_out0  = data_out0_q;
  assign data_out1  = data_out1_q;
  assign valid_out0 = valid_out0_q;
  assign valid_out1 = valid_out1_q;
  assign pending    = (state_q == HALF);

endmodule

// File: tb/tb_demux_striping.sv
// -----------------------------------------------------------------------------
// tb_demux_striping
//
// Scoreboard bench for demux_striping. The stimulus process pushes the
// expected lane contents for every valid output cycle; a monitor on the
// falling edge pops and compares whenever valid_out0 is high, and also
// rebuilds the original word order the way an unstriping mux would.
// -----------------------------------------------------------------------------
module tb_demux_striping;

  localparam int WIDTH = 32;

  logic             clk_2f;
  logic             reset_L;
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic [WIDTH-1:0] data_out0;
  logic             valid_out0;
  logic [WIDTH-1:0] data_out1;
  logic             valid_out1;
  logic             pending;

  demux_striping #(.WIDTH(WIDTH)) dut (
    .clk_2f     (clk_2f),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out0  (data_out0),
    .valid_out0 (valid_out0),
    .data_out1  (data_out1),
    .valid_out1 (valid_out1),
    .pending    (pending)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  typedef struct packed {
    logic [WIDTH-1:0] d0;
    logic             v1;
    logic [WIDTH-1:0] d1;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] recon[$];
  int               tests = 0;
  int               fails = 0;
  bit               phase = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One output load is visible for two consecutive cycles.
  task automatic expect_load(input logic [WIDTH-1:0] d0, input logic v1,
                             input logic [WIDTH-1:0] d1);
    exp_t e;
    e.d0 = d0;
    e.v1 = v1;
    e.d1 = d1;
    sb.push_back(e);
    sb.push_back(e);
  endtask

  task automatic send(input logic v, input logic [WIDTH-1:0] d);
    @(posedge clk_2f);
    #1;
    valid_in = v;
    data_in  = d;
  endtask

  // Drive one cycle, then check pending as left by the previous edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic exp_pend);
    send(v, d);
    @(negedge clk_2f);
    check("pending", {63'd0, pending}, {63'd0, exp_pend});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_2f);
      if (sb.size() == 0 && !valid_out0 && !valid_out1) break;
    end
    check({name, "_drain_q"}, 64'(sb.size()), 64'd0);
    check({name, "_drain_vld"}, {62'd0, valid_out0, valid_out1}, 64'd0);
    sb.delete();
  endtask

  // Monitor: scoreboard compare plus unstriping reconstruction.
  always @(negedge clk_2f) begin
    exp_t e;
    if (valid_out0) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got d0=0x%0h v1=%0b d1=0x%0h expected no output",
                 data_out0, valid_out1, data_out1);
      end else begin
        e = sb.pop_front();
        check("lane0", {32'd0, data_out0}, {32'd0, e.d0});
        check("valid1", {63'd0, valid_out1}, {63'd0, e.v1});
        check("lane1", {32'd0, data_out1}, {32'd0, e.d1});
      end
      if (!phase) begin
        recon.push_back(data_out0);
        if (valid_out1) recon.push_back(data_out1);
      end
      phase = ~phase;
    end else begin
      phase = 1'b0;
      if (valid_out1) begin
        tests++;
        fails++;
        $display("FAIL lane1_alone: got valid_out1=1 expected 0 with valid_out0=0");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within budget");
    $fatal(1, "timeout");
  end

  initial begin
    reset_L  = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;

    // Reset: clear must appear without any clock edge.
    #3 reset_L = 1'b0;
    #1;
    check("rst_async_v0", {63'd0, valid_out0}, 64'd0);
    check("rst_async_pend", {63'd0, pending}, 64'd0);
    check("rst_async_d0", {32'd0, data_out0}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      send(1'b1, (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0000);
      @(negedge clk_2f);
      check("rst_hold_out", {data_out0, data_out1}, 64'd0);
      check("rst_hold_ctl", {61'd0, valid_out0, valid_out1, pending}, 64'd0);
    end
    @(posedge clk_2f);
    #2;
    valid_in = 1'b0;
    reset_L  = 1'b1;
    #1;
    check("rst_release", {61'd0, valid_out0, valid_out1, pending}, 64'd0);

    // Even burst: two pairs back to back, valid for four cycles.
    expect_load(32'hEEEE_EEE0, 1'b1, 32'hEEEE_EEE1);
    expect_load(32'hEEEE_EEE2, 1'b1, 32'hEEEE_EEE3);
    step(1'b1, 32'hEEEE_EEE0, 1'b0);
    step(1'b1, 32'hEEEE_EEE1, 1'b1);
    step(1'b1, 32'hEEEE_EEE2, 1'b0);
    step(1'b1, 32'hEEEE_EEE3, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    drain("even");
    check("even_hold_d0", {32'd0, data_out0}, 64'h0000_0000_EEEE_EEE2);
    check("even_hold_d1", {32'd0, data_out1}, 64'h0000_0000_EEEE_EEE3);

    // Odd burst: final word flushed alone; lane 1 keeps its old data.
    expect_load(32'h0000_00A0, 1'b1, 32'h0000_00A1);
    expect_load(32'h0000_00A2, 1'b0, 32'h0000_00A1);
    step(1'b1, 32'h0000_00A0, 1'b0);
    step(1'b1, 32'h0000_00A1, 1'b1);
    step(1'b1, 32'h0000_00A2, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    drain("odd");

    // Gap realignment: B3 restarts on lane 0.
    expect_load(32'h0000_00B0, 1'b1, 32'h0000_00B1);
    expect_load(32'h0000_00B2, 1'b0, 32'h0000_00B1);
    expect_load(32'h0000_00B3, 1'b1, 32'h0000_00B4);
    step(1'b1, 32'h0000_00B0, 1'b0);
    step(1'b1, 32'h0000_00B1, 1'b1);
    step(1'b1, 32'h0000_00B2, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_00B3, 1'b0);
    step(1'b1, 32'h0000_00B4, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    drain("gap");

    // Reset mid-operation with a pair held and C0 buffered.
    sb.push_back('{d0: 32'h0000_00D0, v1: 1'b1, d1: 32'h0000_00D1});
    step(1'b1, 32'h0000_00D0, 1'b0);
    step(1'b1, 32'h0000_00D1, 1'b1);
    step(1'b1, 32'h0000_00C0, 1'b0);
    @(posedge clk_2f);
    #2;
    valid_in = 1'b0;
    reset_L  = 1'b0;
    #1;
    check("midrst_pend", {63'd0, pending}, 64'd0);
    check("midrst_vld", {62'd0, valid_out0, valid_out1}, 64'd0);
    check("midrst_data", {data_out0, data_out1}, 64'd0);
    @(posedge clk_2f);
    #2 reset_L = 1'b1;
    expect_load(32'h0000_00C1, 1'b1, 32'h0000_00C2);
    step(1'b1, 32'h0000_00C1, 1'b0);
    step(1'b1, 32'h0000_00C2, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    drain("midrst");

    // Loopback: 16-word incrementing stream must be rebuilt in order.
    recon.delete();
    for (int i = 0; i < 16; i += 2)
      expect_load(32'h100 + 32'(i), 1'b1, 32'h101 + 32'(i));
    for (int i = 0; i < 16; i++) send(1'b1, 32'h100 + 32'(i));
    send(1'b0, 32'h0);
    drain("loop");
    check("loop_len", 64'(recon.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < recon.size())
        check("loop_word", {32'd0, recon[i]}, 64'(32'h100 + 32'(i)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
